// File: rtl/block_shift_stacker_if.sv
// Bus between the game controller and the shifting block:
// the block and row inputs, the movement controls and the landing results.
interface block_shift_stacker_if #(
  parameter int ROW_W = 8
);
  localparam int WW = $clog2(ROW_W + 1);

  logic             load;
  logic [ROW_W-1:0] loadBlock;
  logic             firstRow;
  logic [ROW_W-1:0] belowRow;
  logic             stepPulse;
  logic             stopBtn;
  logic [ROW_W-1:0] rowOut;
  logic [ROW_W-1:0] landedRow;
  logic [WW-1:0]    widthOut;
  logic             miss;
  logic             busy;
  logic             done;

  modport master (
    output load, loadBlock, firstRow, belowRow, stepPulse, stopBtn,
    input  rowOut, landedRow, widthOut, miss, busy, done
  );

  modport slave (
    input  load, loadBlock, firstRow, belowRow, stepPulse, stopBtn,
    output rowOut, landedRow, widthOut, miss, busy, done
  );
endinterface

// File: rtl/block_shift_stacker.sv
// Bounces a multi-cell block across a row until stop is pressed,
// then trims it against the row beneath and reports the survivors.
module block_shift_stacker #(
  parameter int ROW_W     = 8,
  parameter int STEP_DIV  = 1,
  parameter bit START_DIR = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  block_shift_stacker_if.slave bus
);
  localparam int WW = $clog2(ROW_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LAND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r, stateNext_s;
  logic [ROW_W-1:0] rowOut_r, rowNext_s;
  logic [ROW_W-1:0] landed_r, landedNext_s;
  logic [WW-1:0]    width_r, widthNext_s;
  logic             miss_r, missNext_s;
  logic             dirLeft_r, dirNext_s;
  logic [7:0]       div_r, divNext_s;
  logic             firstRow_r, firstRowNext_s;
  logic             stopPrev_r;
  logic             busy_r;
  logic             done_r;
  logic             stopRise_s;
  logic [ROW_W-1:0] masked_s;

  function automatic logic [WW-1:0] popCount(input logic [ROW_W-1:0] v);
    logic [WW-1:0] cnt;
    cnt = {WW{1'b0}};
    for (int i = 0; i < ROW_W; i++) begin
      cnt = cnt + WW'(v[i]);
    end
    return cnt;
  endfunction

  // Next-state and datapath decode for the four-phase row cycle
  always_comb begin
    stateNext_s    = state_r;
    rowNext_s      = rowOut_r;
    landedNext_s   = landed_r;
    widthNext_s    = width_r;
    missNext_s     = miss_r;
    dirNext_s      = dirLeft_r;
    divNext_s      = div_r;
    firstRowNext_s = firstRow_r;
    stopRise_s     = bus.stopBtn & ~stopPrev_r;
    masked_s       = rowOut_r & (firstRow_r ? {ROW_W{1'b1}} : bus.belowRow);

    case (state_r)
      IDLE: begin
        if (bus.load) begin
          rowNext_s      = bus.loadBlock;
          dirNext_s      = START_DIR;
          divNext_s      = 8'd0;
          firstRowNext_s = bus.firstRow;
          landedNext_s   = {ROW_W{1'b0}};
          widthNext_s    = {WW{1'b0}};
          missNext_s     = 1'b0;
          stateNext_s    = (bus.loadBlock == {ROW_W{1'b0}}) ? LAND : SHIFT;
        end else begin
          stateNext_s = IDLE;
        end
      end
      SHIFT: begin
        if (stopRise_s) begin
          stateNext_s = LAND;
        end else if (bus.stepPulse) begin
          if (div_r == 8'(STEP_DIV - 1)) begin
            divNext_s = 8'd0;
            // Reverse on the edge cell in the same move, so the block never dwells
            if (rowOut_r[0] && rowOut_r[ROW_W-1]) begin
              dirNext_s = ~dirLeft_r;
            end else if (!dirLeft_r) begin
              if (rowOut_r[0]) begin
                dirNext_s = 1'b1;
                rowNext_s = rowOut_r << 1;
              end else begin
                rowNext_s = rowOut_r >> 1;
              end
            end else begin
              if (rowOut_r[ROW_W-1]) begin
                dirNext_s = 1'b0;
                rowNext_s = rowOut_r >> 1;
              end else begin
                rowNext_s = rowOut_r << 1;
              end
            end
          end else begin
            divNext_s = div_r + 8'd1;
          end
        end else begin
          stateNext_s = SHIFT;
        end
      end
      LAND: begin
        landedNext_s = masked_s;
        widthNext_s  = popCount(masked_s);
        missNext_s   = (masked_s == {ROW_W{1'b0}});
        rowNext_s    = masked_s;
        stateNext_s  = DONE;
      end
      DONE: begin
        stateNext_s = IDLE;
      end
      default: begin
        stateNext_s = IDLE;
      end
    endcase
  end

  // State and output registers; busy/done decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      rowOut_r   <= {ROW_W{1'b0}};
      landed_r   <= {ROW_W{1'b0}};
      width_r    <= {WW{1'b0}};
      miss_r     <= 1'b0;
      dirLeft_r  <= START_DIR;
      div_r      <= 8'd0;
      firstRow_r <= 1'b0;
      stopPrev_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      rowOut_r   <= rowNext_s;
      landed_r   <= landedNext_s;
      width_r    <= widthNext_s;
      miss_r     <= missNext_s;
      dirLeft_r  <= dirNext_s;
      div_r      <= divNext_s;
      firstRow_r <= firstRowNext_s;
      stopPrev_r <= bus.stopBtn;
      busy_r     <= (stateNext_s != IDLE);
      done_r     <= (stateNext_s == DONE);
    end
  end

  assign bus.rowOut    = rowOut_r;
  assign bus.landedRow = landed_r;
  assign bus.widthOut  = width_r;
  assign bus.miss      = miss_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_block_shift_stacker.sv
// Drives two stackers (speed divider 1 and 3) with shared stimulus and
// checks both against a position/length model of the bouncing block.
module tb_block_shift_stacker;
  logic clk = 1'b0;
  logic rst;
  logic load, firstRow, stepPulse, stopBtn;
  logic [7:0] loadBlock, belowRow;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  block_shift_stacker_if #(.ROW_W(8)) bus1 ();
  block_shift_stacker_if #(.ROW_W(8)) bus3 ();

  assign bus1.load = load;       assign bus3.load = load;
  assign bus1.loadBlock = loadBlock; assign bus3.loadBlock = loadBlock;
  assign bus1.firstRow = firstRow;   assign bus3.firstRow = firstRow;
  assign bus1.belowRow = belowRow;   assign bus3.belowRow = belowRow;
  assign bus1.stepPulse = stepPulse; assign bus3.stepPulse = stepPulse;
  assign bus1.stopBtn = stopBtn;     assign bus3.stopBtn = stopBtn;

  block_shift_stacker #(.ROW_W(8), .STEP_DIV(1), .START_DIR(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  block_shift_stacker #(.ROW_W(8), .STEP_DIV(3), .START_DIR(1'b0)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave));

  // Inputs as seen at the active edge
  logic sRst, sLoad, sFirst, sStep, sStop, sSeen = 1'b0;
  logic [7:0] sBlock, sBelow;
  always @(posedge clk) begin
    sRst <= rst; sLoad <= load; sFirst <= firstRow; sStep <= stepPulse;
    sStop <= stopBtn; sBlock <= loadBlock; sBelow <= belowRow; sSeen <= 1'b1;
  end

  // Model: phase 0 idle, 1 moving, 2 landing, 3 finished; block = len cells starting at lo
  int mPhase[2], mLo[2], mLen[2], mDiv[2], mWidth[2];
  bit mDir[2], mFr[2], mMiss[2], mValid[2];
  logic [7:0] mRow[2], mLanded[2];
  bit mStopPrev = 1'b0;

  function automatic logic [7:0] cells(int lo, int len);
    return 8'(((1 << len) - 1) << lo);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic moveBlock(int k);
    if (mLen[k] == 8) mDir[k] = ~mDir[k];
    else if (!mDir[k]) begin
      if (mLo[k] == 0) begin mDir[k] = 1'b1; mLo[k] = 1; end
      else mLo[k] = mLo[k] - 1;
    end else begin
      if (mLo[k] + mLen[k] == 8) begin mDir[k] = 1'b0; mLo[k] = mLo[k] - 1; end
      else mLo[k] = mLo[k] + 1;
    end
    mRow[k] = cells(mLo[k], mLen[k]);
  endtask

  task automatic modelStep();
    bit rise;
    logic [7:0] m;
    rise = sStop && !mStopPrev;
    for (int k = 0; k < 2; k++) begin
      int sd;
      sd = (k == 0) ? 1 : 3;
      if (sRst) begin
        mPhase[k] = 0; mRow[k] = 8'h00; mLanded[k] = 8'h00; mWidth[k] = 0;
        mMiss[k] = 1'b0; mDir[k] = 1'b0; mDiv[k] = 0; mValid[k] = 1'b1;
      end else begin
        case (mPhase[k])
          0: if (sLoad) begin
            mRow[k] = sBlock; mLen[k] = $countones(sBlock); mLo[k] = 0;
            for (int i = 7; i >= 0; i--) if (sBlock[i]) mLo[k] = i;
            mDir[k] = 1'b0; mDiv[k] = 0; mFr[k] = sFirst; mValid[k] = 1'b0;
            mPhase[k] = (sBlock == 8'h00) ? 2 : 1;
          end
          1: if (rise) mPhase[k] = 2;
             else if (sStep) begin
               if (mDiv[k] == sd - 1) begin mDiv[k] = 0; moveBlock(k); end
               else mDiv[k] = mDiv[k] + 1;
             end
          2: begin
            m = mRow[k] & (mFr[k] ? 8'hFF : sBelow);
            mLanded[k] = m; mRow[k] = m; mWidth[k] = $countones(m);
            mMiss[k] = (m == 8'h00); mValid[k] = 1'b1; mPhase[k] = 3;
          end
          default: mPhase[k] = 0;
        endcase
      end
    end
    mStopPrev = sRst ? 1'b0 : sStop;
  endtask

  task automatic compareOne(int k, logic [7:0] r, logic [7:0] l, logic [3:0] w,
                            logic ms, logic b, logic d);
    chk(k == 0 ? "rowOut/div1" : "rowOut/div3", {24'd0, r}, {24'd0, mRow[k]});
    chk(k == 0 ? "busy/div1" : "busy/div3", {31'd0, b}, {31'd0, mPhase[k] != 0});
    chk(k == 0 ? "done/div1" : "done/div3", {31'd0, d}, {31'd0, mPhase[k] == 3});
    if (mValid[k]) begin
      chk(k == 0 ? "landedRow/div1" : "landedRow/div3", {24'd0, l}, {24'd0, mLanded[k]});
      chk(k == 0 ? "widthOut/div1" : "widthOut/div3", {28'd0, w}, 32'(mWidth[k]));
      chk(k == 0 ? "miss/div1" : "miss/div3", {31'd0, ms}, {31'd0, mMiss[k]});
    end
  endtask

  // Advance the model once per edge and compare both designs on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (sSeen) begin
        modelStep();
        compareOne(0, bus1.rowOut, bus1.landedRow, bus1.widthOut, bus1.miss, bus1.busy, bus1.done);
        compareOne(1, bus3.rowOut, bus3.landedRow, bus3.widthOut, bus3.miss, bus3.busy, bus3.done);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doLoad(logic [7:0] blk, logic fr);
    load = 1'b1; loadBlock = blk; firstRow = fr; cyc(1); load = 1'b0;
  endtask

  task automatic doStep();
    stepPulse = 1'b1; cyc(1); stepPulse = 1'b0;
  endtask

  task automatic press();
    stopBtn = 1'b1; cyc(1); stopBtn = 1'b0;
  endtask

  logic [7:0] bounceExp [9] = '{8'b00011100, 8'b00001110, 8'b00000111, 8'b00001110,
                                8'b00011100, 8'b00111000, 8'b01110000, 8'b11100000, 8'b01110000};
  logic [7:0] divExp [6] = '{8'b00011000, 8'b00011000, 8'b00001100,
                             8'b00001100, 8'b00001100, 8'b00000110};

  initial begin
    rst = 1'b1; load = 1'b0; firstRow = 1'b0; stepPulse = 1'b0; stopBtn = 1'b0;
    loadBlock = 8'h00; belowRow = 8'h00;
    cyc(3);
    chk("reset rowOut", {24'd0, bus1.rowOut}, 32'd0);
    chk("reset busy", {31'd0, bus1.busy}, 32'd0);
    rst = 1'b0;
    cyc(1);

    // Bounce with no dwell at the edges
    doLoad(8'b00111000, 1'b1);
    for (int i = 0; i < 9; i++) begin
      doStep();
      chk("bounce", {24'd0, bus1.rowOut}, {24'd0, bounceExp[i]});
    end
    press(); cyc(1); cyc(1);

    // Divider of three
    doLoad(8'b00011000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      doStep();
      chk("divider", {24'd0, bus3.rowOut}, {24'd0, divExp[i]});
    end
    press(); cyc(2);

    // Trim against the row below
    doLoad(8'b00000111, 1'b0);
    belowRow = 8'b00001110;
    press();
    chk("trim done early", {31'd0, bus1.done}, 32'd0);
    cyc(1);
    chk("trim done", {31'd0, bus1.done}, 32'd1);
    chk("trim rowOut", {24'd0, bus1.rowOut}, 32'b00000110);
    chk("trim landed", {24'd0, bus1.landedRow}, 32'b00000110);
    chk("trim width", {28'd0, bus1.widthOut}, 32'd2);
    chk("trim miss", {31'd0, bus1.miss}, 32'd0);
    cyc(1);
    chk("trim hold", {24'd0, bus1.landedRow}, 32'b00000110);

    // Miss, then first row
    doLoad(8'b00000111, 1'b0);
    belowRow = 8'b11000000;
    press(); cyc(1);
    chk("miss landed", {24'd0, bus1.landedRow}, 32'd0);
    chk("miss flag", {31'd0, bus1.miss}, 32'd1);
    cyc(1);
    doLoad(8'b00000111, 1'b1);
    press(); cyc(1);
    chk("firstRow landed", {24'd0, bus1.landedRow}, 32'b00000111);
    chk("firstRow width", {28'd0, bus1.widthOut}, 32'd3);
    cyc(1);

    // Stop and step together
    doLoad(8'b00111000, 1'b1);
    stepPulse = 1'b1; stopBtn = 1'b1; cyc(1); stepPulse = 1'b0; stopBtn = 1'b0;
    cyc(1);
    chk("stop+step landed", {24'd0, bus1.landedRow}, 32'b00111000);
    cyc(1);

    // Button held through load
    stopBtn = 1'b1; cyc(1);
    doLoad(8'b00011000, 1'b1);
    cyc(3);
    chk("held busy", {31'd0, bus1.busy}, 32'd1);
    stopBtn = 1'b0; cyc(1);
    press(); cyc(1);
    chk("held release done", {31'd0, bus1.done}, 32'd1);
    cyc(1);

    // Load while shifting is ignored
    doLoad(8'b00110000, 1'b1);
    doStep();
    doLoad(8'b11000000, 1'b1);
    chk("load ignored", {24'd0, bus1.rowOut}, 32'b00011000);
    doStep();
    chk("load ignored step", {24'd0, bus1.rowOut}, 32'b00001100);
    press(); cyc(2);

    // Reset mid-shift, then an empty block
    doLoad(8'b01110000, 1'b1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("abort rowOut", {24'd0, bus1.rowOut}, 32'd0);
    chk("abort busy", {31'd0, bus1.busy}, 32'd0);
    doLoad(8'h00, 1'b0);
    chk("empty not done", {31'd0, bus1.done}, 32'd0);
    cyc(1);
    chk("empty done", {31'd0, bus1.done}, 32'd1);
    chk("empty miss", {31'd0, bus1.miss}, 32'd1);
    cyc(1);

    // Random play
    for (int n = 0; n < 4000; n++) begin
      int len, lo, sel;
      rst = ($urandom_range(0, 299) == 0);
      load = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 8);
      lo = $urandom_range(0, 8 - len);
      loadBlock = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : cells(lo, len);
      firstRow = $urandom_range(0, 1);
      belowRow = 8'($urandom);
      stepPulse = $urandom_range(0, 1);
      if ($urandom_range(0, 19) == 0) stopBtn = ~stopBtn;
      cyc(1);
    end
    rst = 1'b0; load = 1'b0; stepPulse = 1'b0;
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
